// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, memory and status signals of the dual-cache memory arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
);
    logic              m0_enable_i, m1_enable_i;
    logic              m0_write_i, m1_write_i;
    logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
    logic [DATA_W-1:0] m0_data_i, m1_data_i;
    logic              m0_ack_o, m1_ack_o;
    logic [DATA_W-1:0] m_data_o;
    logic              mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [1:0]        grant_o;
    logic              busy_o;
    logic              err_o;
    modport slave (
        input  m0_enable_i, m1_enable_i, m0_write_i, m1_write_i,
               m0_addr_i, m1_addr_i, m0_data_i, m1_data_i, mem_data_i, mem_ack_i,
        output m0_ack_o, m1_ack_o, m_data_o, mem_enable_o, mem_write_o,
               mem_addr_o, mem_data_o, grant_o, busy_o, err_o
    );
    modport master (
        output m0_enable_i, m1_enable_i, m0_write_i, m1_write_i,
               m0_addr_i, m1_addr_i, m0_data_i, m1_data_i, mem_data_i, mem_ack_i,
        input  m0_ack_o, m1_ack_o, m_data_o, mem_enable_o, mem_write_o,
               mem_addr_o, mem_data_o, grant_o, busy_o, err_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter giving icache (m0) and dcache (m1) turns at one line-wide memory port.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 255
) (
    input logic           clk_i,
    input logic           rst_i,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [1:0]        grant_q, grant_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              pick_m1, ack;
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        // on a tie the requester not served last wins
        pick_m1 = bus.m1_enable_i & (~bus.m0_enable_i | ~last_q);
        ack     = (state_q == BUSY) & bus.mem_ack_i;
        case (state_q)
            IDLE: if (bus.m0_enable_i | bus.m1_enable_i) begin
                state_d = BUSY;
                grant_d = pick_m1 ? 2'b10 : 2'b01;
                write_d = pick_m1 ? bus.m1_write_i : bus.m0_write_i;
                addr_d  = pick_m1 ? bus.m1_addr_i : bus.m0_addr_i;
                data_d  = pick_m1 ? bus.m1_data_i : bus.m0_data_i;
                cnt_d   = '0;
            end
            BUSY: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                err_d = err_q | (cnt_d == CNT_MAX);
                state_d = ack ? DONE : BUSY;
                last_d  = ack ? grant_q[1] : last_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    assign bus.mem_enable_o = state_q == BUSY;
    assign bus.mem_write_o  = (state_q == BUSY) & write_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_data_o   = data_q;
    assign bus.grant_o      = (state_q == BUSY) ? grant_q : 2'b00;
    assign bus.busy_o       = state_q != IDLE;
    assign bus.err_o        = err_q;
    assign bus.m0_ack_o     = ack & grant_q[0];
    assign bus.m1_ack_o     = ack & grant_q[1];
    assign bus.m_data_o     = bus.mem_data_i;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, latching, ack, timeout and reset behaviour.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    int   fails = 0;
    logic [255:0] rd_line = {8{32'hDEADBEEF}};
    logic [255:0] a5_line = {32{8'hA5}};
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(256)) bus ();
    dmem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic reset_pulse();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask
    initial begin
        bus.m0_enable_i = 0; bus.m1_enable_i = 0;
        bus.m0_write_i = 0;  bus.m1_write_i = 0;
        bus.m0_addr_i = '0;  bus.m1_addr_i = '0;
        bus.m0_data_i = '0;  bus.m1_data_i = '0;
        bus.mem_data_i = rd_line;
        bus.mem_ack_i = 0;
        cyc(2);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_en", bus.mem_enable_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_addr", bus.mem_addr_o, 0);
        rst = 1'b0;
        // m0 read, acked in the 10th BUSY cycle
        bus.m0_enable_i = 1; bus.m0_addr_i = 32'h0000_0400;
        cyc();
        chk("rd_grant", bus.grant_o, 2'b01);
        chk("rd_addr", bus.mem_addr_o, 32'h400);
        chk("rd_write", bus.mem_write_o, 0);
        for (int i = 1; i <= 9; i++) begin
            chk("rd_en", bus.mem_enable_o, 1);
            chk("rd_noack", bus.m0_ack_o, 0);
            chk("rd_err", bus.err_o, i >= 9);
            cyc();
        end
        bus.mem_ack_i = 1;
        #1;
        chk("rd_en10", bus.mem_enable_o, 1);
        chk("rd_ack", bus.m0_ack_o, 1);
        chk("rd_ack_other", bus.m1_ack_o, 0);
        chk("rd_data", bus.m_data_o, rd_line);
        cyc();
        bus.mem_ack_i = 0; bus.m0_enable_i = 0;
        #1;
        chk("done_busy", bus.busy_o, 1);
        chk("done_en", bus.mem_enable_o, 0);
        chk("done_grant", bus.grant_o, 0);
        chk("done_ack", bus.m0_ack_o, 0);
        cyc();
        chk("idle_busy", bus.busy_o, 0);
        // simultaneous requests alternate
        reset_pulse();
        bus.m0_enable_i = 1; bus.m0_addr_i = 32'h100;
        bus.m1_enable_i = 1; bus.m1_addr_i = 32'h200;
        cyc();
        chk("rr1_grant", bus.grant_o, 2'b01);
        chk("rr1_addr", bus.mem_addr_o, 32'h100);
        bus.mem_ack_i = 1;
        #1;
        chk("rr1_ack0", bus.m0_ack_o, 1);
        chk("rr1_ack1", bus.m1_ack_o, 0);
        cyc();
        bus.mem_ack_i = 0; bus.m0_enable_i = 0;
        chk("rr1_done", bus.grant_o, 0);
        cyc();
        chk("rr_idle", bus.busy_o, 0);
        cyc();
        chk("rr2_grant", bus.grant_o, 2'b10);
        chk("rr2_addr", bus.mem_addr_o, 32'h200);
        bus.mem_ack_i = 1;
        #1;
        chk("rr2_ack1", bus.m1_ack_o, 1);
        chk("rr2_ack0", bus.m0_ack_o, 0);
        cyc();
        bus.mem_ack_i = 0; bus.m1_enable_i = 0;
        cyc();
        bus.m0_enable_i = 1; bus.m1_enable_i = 1;
        cyc();
        chk("rr3_grant", bus.grant_o, 2'b01);
        bus.mem_ack_i = 1;
        cyc();
        bus.mem_ack_i = 0; bus.m0_enable_i = 0; bus.m1_enable_i = 0;
        cyc();
        // m1 write holds latched values while inputs change
        bus.m1_enable_i = 1; bus.m1_write_i = 1;
        bus.m1_addr_i = 32'h0000_1FE0; bus.m1_data_i = a5_line;
        cyc();
        chk("wr_grant", bus.grant_o, 2'b10);
        bus.m1_addr_i = 32'h3000; bus.m1_data_i = '0; bus.m1_write_i = 0; bus.m1_enable_i = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("wr_addr", bus.mem_addr_o, 32'h1FE0);
            chk("wr_data", bus.mem_data_o, a5_line);
            chk("wr_write", bus.mem_write_o, 1);
        end
        bus.mem_ack_i = 1;
        #1;
        chk("wr_ack", bus.m1_ack_o, 1);
        cyc();
        bus.mem_ack_i = 0;
        chk("wr_done_write", bus.mem_write_o, 0);
        cyc();
        // mem_ack_i outside BUSY is ignored
        bus.mem_ack_i = 1;
        #1;
        chk("idle_ack0", bus.m0_ack_o, 0);
        chk("idle_ack1", bus.m1_ack_o, 0);
        cyc();
        chk("idle_stay", bus.busy_o, 0);
        bus.mem_ack_i = 0; bus.m0_enable_i = 1; bus.m0_addr_i = 32'h40;
        cyc();
        bus.mem_ack_i = 1;
        cyc();
        bus.m0_enable_i = 0;
        #1;
        chk("done_ack0", bus.m0_ack_o, 0);
        chk("done_ack1", bus.m1_ack_o, 0);
        chk("done_state", bus.busy_o, 1);
        cyc();
        chk("done_to_idle", bus.busy_o, 0);
        chk("idle_ack_hold", bus.m0_ack_o, 0);
        bus.mem_ack_i = 0;
        // timeout: err after 8 BUSY cycles, sticky until reset
        reset_pulse();
        chk("to_err_rst", bus.err_o, 0);
        bus.m0_enable_i = 1; bus.m0_addr_i = 32'h800;
        cyc();
        for (int i = 1; i <= 19; i++) begin
            chk("to_err", bus.err_o, i >= 9);
            cyc();
        end
        bus.mem_ack_i = 1;
        #1;
        chk("to_ack", bus.m0_ack_o, 1);
        cyc();
        bus.mem_ack_i = 0; bus.m0_enable_i = 0;
        chk("to_done_busy", bus.busy_o, 1);
        cyc(4);
        chk("to_err_sticky", bus.err_o, 1);
        chk("to_idle", bus.busy_o, 0);
        reset_pulse();
        chk("to_err_clr", bus.err_o, 0);
        // reset in BUSY cycle 3 aborts the transfer
        bus.m1_enable_i = 1; bus.m1_write_i = 1; bus.m1_addr_i = 32'h600; bus.m1_data_i = a5_line;
        cyc();
        chk("ab_grant", bus.grant_o, 2'b10);
        cyc(2);
        bus.mem_ack_i = 1;
        rst = 1'b1;
        #1;
        chk("ab_en", bus.mem_enable_o, 0);
        chk("ab_grant0", bus.grant_o, 0);
        chk("ab_busy", bus.busy_o, 0);
        chk("ab_addr", bus.mem_addr_o, 0);
        chk("ab_data", bus.mem_data_o, 0);
        chk("ab_write", bus.mem_write_o, 0);
        chk("ab_ack", bus.m1_ack_o, 0);
        cyc();
        rst = 1'b0; bus.mem_ack_i = 0;
        #1;
        chk("ab_rel_grant", bus.grant_o, 0);
        cyc();
        chk("ab_regrant", bus.grant_o, 2'b10);
        chk("ab_readdr", bus.mem_addr_o, 32'h600);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
